clk_tick_gen: RTL

- Parametrised successor to the fixed top-level clock divider.
- Generates a one-cycle clock-enable `tick` and a matching square wave `clk_sq` from `clk`. The core is clocked from `clk` and gated by `tick`, so no derived clock exists.
- Adds a runtime-loadable divisor, HALT/RUN/STEP modes for single-stepping the RISC-V core, and a tick counter for the seven-segment debug display.

---
 rtl/clk_tick_gen_if.sv | 27 ++
 rtl/clk_tick_gen.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/clk_tick_gen_if.sv
// Bus interface for clk_tick_gen: mode/step control, divisor load port and
// the tick, square-wave and counter outputs. The controller side uses
// the master modport and clk_tick_gen uses the slave modport.
interface clk_tick_gen_if #(
    parameter int DIV_W      = 32,
    parameter int TICK_CNT_W = 16
);
    logic [1:0]            mode;
    logic                  step;
    logic [DIV_W-1:0]      div_in;
    logic                  div_load;
    logic                  div_pending;
    logic                  tick;
    logic                  clk_sq;
    logic [DIV_W-1:0]      cnt;
    logic [TICK_CNT_W-1:0] tick_count;

    modport master (
        output mode, step, div_in, div_load,
        input  div_pending, tick, clk_sq, cnt, tick_count
    );

    modport slave (
        input  mode, step, div_in, div_load,
        output div_pending, tick, clk_sq, cnt, tick_count
    );
endinterface

// File: rtl/clk_tick_gen.sv
// clk_tick_gen: programmable clock-enable generator with a runtime-loadable
// divisor, HALT/RUN/STEP modes and a wrapping tick counter.
// Optional macro STEP_SYNC_EN: when defined, `step` passes a 2-flop
// synchroniser and a debouncer before edge detection; when undefined,
// `step` is treated as synchronous to clk.
module clk_tick_gen #(
    parameter int DIV_W           = 32,
    parameter int DEFAULT_DIV     = 10000000,
    parameter int TICK_CNT_W      = 16,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic          clk,
    input  logic          reset,
    clk_tick_gen_if.slave bus
);

    typedef enum logic [1:0] {
        MODE_HALT = 2'b00,
        MODE_RUN  = 2'b01,
        MODE_STEP = 2'b10,
        MODE_RSVD = 2'b11
    } mode_e;

    localparam logic [DIV_W-1:0] DEFAULT_DIV_C = DIV_W'(DEFAULT_DIV);

    // Reject divisor/debounce settings that would break the counter logic.
    if (DEFAULT_DIV < 1 || DEBOUNCE_CYCLES < 1) begin : g_bad_param
        $error("clk_tick_gen: DEFAULT_DIV and DEBOUNCE_CYCLES must be >= 1");
    end

    // Divider state
    logic [DIV_W-1:0]      cnt_q, cnt_d;
    logic [DIV_W-1:0]      div_active_q, div_active_d;
    logic [DIV_W-1:0]      div_pend_val_q, div_pend_val_d;
    logic                  pending_q, pending_d;
    logic                  tick_q, tick_d;
    logic                  clk_sq_q, clk_sq_d;
    logic [TICK_CNT_W-1:0] tick_count_q, tick_count_d;

    // Step edge detection
    logic step_lvl;
    logic step_prev_q;
    logic step_rise;

`ifdef STEP_SYNC_EN
    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [1:0]      sync_q;
    logic [DB_W-1:0] db_cnt_q;
    logic            db_level_q;

    // Synchronise step, then accept a new level only after it has been stable long enough.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q     <= '0;
            db_cnt_q   <= '0;
            db_level_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], bus.step};
            if (sync_q[1] == db_level_q) begin
                db_cnt_q <= '0;
            end else if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                db_level_q <= sync_q[1];
                db_cnt_q   <= '0;
            end else begin
                db_cnt_q <= db_cnt_q + 1'b1;
            end
        end
    end

    assign step_lvl = db_level_q;
`else
    assign step_lvl = bus.step;
`endif

    assign step_rise = step_lvl & ~step_prev_q;

    // Next-state logic for counter, divisor, tick and square wave.
    always_comb begin
        logic [DIV_W-1:0] load_val;
        logic             wrap;

        // NOTE: every variable gets a default before any branch so no latch is inferred;
        // combinational logic uses blocking '=' while the flops below use '<='.
        cnt_d          = cnt_q;
        div_active_d   = div_active_q;
        div_pend_val_d = div_pend_val_q;
        pending_d      = pending_q;
        tick_d         = 1'b0;
        clk_sq_d       = clk_sq_q;

        // A zero divisor would never wrap, so it is stored as 1.
        load_val = (bus.div_in == '0) ? DIV_W'(1) : bus.div_in;
        // '>=' keeps cnt bounded even if the divisor ever shrank under it.
        wrap     = (cnt_q >= div_active_q - 1'b1);

        if (bus.div_load) begin
            div_pend_val_d = load_val;
            pending_d      = 1'b1;
        end

        case (mode_e'(bus.mode))
            MODE_RUN: begin
                if (wrap) begin
                    cnt_d  = '0;
                    tick_d = 1'b1;
                    // A load arriving on the wrap edge beats the older pending value.
                    if (bus.div_load) begin
                        div_active_d = load_val;
                        pending_d    = 1'b0;
                    end else if (pending_q) begin
                        div_active_d = div_pend_val_q;
                        pending_d    = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
                // High phase is the first ceil(div/2) counts, matching the registered cnt.
                clk_sq_d = ({1'b0, cnt_d} < (({1'b0, div_active_d} + 1'b1) >> 1));
            end

            MODE_STEP: begin
                cnt_d    = '0;
                tick_d   = step_rise;
                clk_sq_d = step_rise;
                if (pending_q) begin
                    div_active_d = div_pend_val_q;
                    pending_d    = bus.div_load;
                end
            end

            default: begin
                // HALT and reserved: freeze, but a waiting divisor is applied immediately.
                if (pending_q) begin
                    div_active_d = div_pend_val_q;
                    pending_d    = bus.div_load;
                    cnt_d        = '0;
                    clk_sq_d     = 1'b1;
                end
            end
        endcase

        tick_count_d = tick_count_q + (tick_d ? TICK_CNT_W'(1) : TICK_CNT_W'(0));
    end

    // State registers with synchronous reset that overrides every input.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q          <= '0;
            div_active_q   <= DEFAULT_DIV_C;
            div_pend_val_q <= '0;
            pending_q      <= 1'b0;
            tick_q         <= 1'b0;
            clk_sq_q       <= 1'b1;
            tick_count_q   <= '0;
            step_prev_q    <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            div_active_q   <= div_active_d;
            div_pend_val_q <= div_pend_val_d;
            pending_q      <= pending_d;
            tick_q         <= tick_d;
            clk_sq_q       <= clk_sq_d;
            tick_count_q   <= tick_count_d;
            // Edge register tracks step in every mode so a level held across a mode change is not an edge.
            step_prev_q    <= step_lvl;
        end
    end

    assign bus.cnt         = cnt_q;
    assign bus.tick        = tick_q;
    assign bus.clk_sq      = clk_sq_q;
    assign bus.div_pending = pending_q;
    assign bus.tick_count  = tick_count_q;

endmodule
